// File: rtl/reg_wb_arbiter_if.sv
// Writeback bus between two requesters and the register-file write port.
// The slave modport is the arbiter's view; the master modport drives requests.
interface reg_wb_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_reg;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_reg;
    logic [31:0] req1_data;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        grant_id;
    logic [7:0]  contend_cnt;

    modport slave (
        input  req0_valid, req0_reg, req0_data,
        input  req1_valid, req1_reg, req1_data,
        output req0_ready, req1_ready,
        output reg_write, write_reg, write_data, grant_id, contend_cnt
    );

    modport master (
        output req0_valid, req0_reg, req0_data,
        output req1_valid, req1_reg, req1_data,
        input  req0_ready, req1_ready,
        input  reg_write, write_reg, write_data, grant_id, contend_cnt
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Two-requester writeback arbiter with one-entry buffers and round-robin ties.
// Define REG_WB_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead.
module reg_wb_arbiter (
    input  logic              clk,
    input  logic              rst,
    reg_wb_arbiter_if.slave   bus
);
    logic        buf0Valid_q, buf0Valid_d;
    logic [4:0]  buf0Reg_q,   buf0Reg_d;
    logic [31:0] buf0Data_q,  buf0Data_d;
    logic        buf1Valid_q, buf1Valid_d;
    logic [4:0]  buf1Reg_q,   buf1Reg_d;
    logic [31:0] buf1Data_q,  buf1Data_d;
`ifndef REG_WB_ARB_FIXED_PRIO_EN
    logic        lastGrant_q, lastGrant_d;
`endif
    logic        regWrite_q,  regWrite_d;
    logic [4:0]  writeReg_q,  writeReg_d;
    logic [31:0] writeData_q, writeData_d;
    logic        grantId_q,   grantId_d;
    logic [7:0]  contendCnt_q, contendCnt_d;

    logic        grant0, grant1, anyGrant, ready0, ready1, accept0, accept1;
    logic [4:0]  winReg;
    logic [31:0] winData;

    always_comb begin
`ifdef REG_WB_ARB_FIXED_PRIO_EN
        grant0 = buf0Valid_q;
`else
        grant0 = buf0Valid_q & (~buf1Valid_q | lastGrant_q);
`endif
        grant1   = buf1Valid_q & ~grant0;
        anyGrant = grant0 | grant1;
        winReg   = grant1 ? buf1Reg_q  : buf0Reg_q;
        winData  = grant1 ? buf1Data_q : buf0Data_q;

        // A granted buffer frees its slot on this edge, so it can refill at once.
        ready0  = ~buf0Valid_q | grant0;
        ready1  = ~buf1Valid_q | grant1;
        accept0 = bus.req0_valid & ready0;
        accept1 = bus.req1_valid & ready1;

        buf0Valid_d = accept0 | (buf0Valid_q & ~grant0);
        buf0Reg_d   = accept0 ? bus.req0_reg  : buf0Reg_q;
        buf0Data_d  = accept0 ? bus.req0_data : buf0Data_q;
        buf1Valid_d = accept1 | (buf1Valid_q & ~grant1);
        buf1Reg_d   = accept1 ? bus.req1_reg  : buf1Reg_q;
        buf1Data_d  = accept1 ? bus.req1_data : buf1Data_q;

`ifndef REG_WB_ARB_FIXED_PRIO_EN
        lastGrant_d = anyGrant ? grant1 : lastGrant_q;
`endif
        // Writes to register 0 are swallowed: the entry drains but no strobe.
        regWrite_d  = anyGrant & (winReg != 5'd0);
        writeReg_d  = anyGrant ? winReg  : writeReg_q;
        writeData_d = anyGrant ? winData : writeData_q;
        grantId_d   = anyGrant ? grant1  : grantId_q;

        contendCnt_d = contendCnt_q;
        if (buf0Valid_q && buf1Valid_q && contendCnt_q != 8'hFF) begin
            contendCnt_d = contendCnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf0Valid_q  <= 1'b0;
            buf0Reg_q    <= '0;
            buf0Data_q   <= '0;
            buf1Valid_q  <= 1'b0;
            buf1Reg_q    <= '0;
            buf1Data_q   <= '0;
`ifndef REG_WB_ARB_FIXED_PRIO_EN
            lastGrant_q  <= 1'b1;
`endif
            regWrite_q   <= 1'b0;
            writeReg_q   <= '0;
            writeData_q  <= '0;
            grantId_q    <= 1'b0;
            contendCnt_q <= '0;
        end else begin
            buf0Valid_q  <= buf0Valid_d;
            buf0Reg_q    <= buf0Reg_d;
            buf0Data_q   <= buf0Data_d;
            buf1Valid_q  <= buf1Valid_d;
            buf1Reg_q    <= buf1Reg_d;
            buf1Data_q   <= buf1Data_d;
`ifndef REG_WB_ARB_FIXED_PRIO_EN
            lastGrant_q  <= lastGrant_d;
`endif
            regWrite_q   <= regWrite_d;
            writeReg_q   <= writeReg_d;
            writeData_q  <= writeData_d;
            grantId_q    <= grantId_d;
            contendCnt_q <= contendCnt_d;
        end
    end

    assign bus.req0_ready  = ready0;
    assign bus.req1_ready  = ready1;
    assign bus.reg_write   = regWrite_q;
    assign bus.write_reg   = writeReg_q;
    assign bus.write_data  = writeData_q;
    assign bus.grant_id    = grantId_q;
    assign bus.contend_cnt = contendCnt_q;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: per-cycle vector table, hand sequences for contention,
// saturation and mid-run reset, plus a per-requester scoreboard of expected writes.
module tb_reg_wb_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    reg_wb_arbiter_if bus();

    reg_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [4:0]  r0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic        eRdy0;
        logic        eRdy1;
        logic        eRw;
        logic        eGid;
        logic [7:0]  eCnt;
    } vec_t;

    vec_t vecs[13];

    // Expected {reg,data} per requester, pushed on handshake, popped on write.
    logic [36:0] q0[$];
    logic [36:0] q1[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs just after the edge, then let ready settle.
    task automatic applyStimulus(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                                 input logic v1, input logic [4:0] r1, input logic [31:0] d1);
        @(posedge clk);
        #1;
        bus.req0_valid = v0;
        bus.req0_reg   = r0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_reg   = r1;
        bus.req1_data  = d1;
        #1;
    endtask

    always @(negedge clk) begin
        logic [36:0] e;
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (bus.reg_write) begin
                if (bus.grant_id == 1'b0) begin
                    if (q0.size() == 0) begin
                        checkOutput("sb0 unexpected write", 32'd1, 32'd0);
                    end else begin
                        e = q0.pop_front();
                        checkOutput("sb0 write_reg", {27'd0, bus.write_reg}, {27'd0, e[36:32]});
                        checkOutput("sb0 write_data", bus.write_data, e[31:0]);
                    end
                end else begin
                    if (q1.size() == 0) begin
                        checkOutput("sb1 unexpected write", 32'd1, 32'd0);
                    end else begin
                        e = q1.pop_front();
                        checkOutput("sb1 write_reg", {27'd0, bus.write_reg}, {27'd0, e[36:32]});
                        checkOutput("sb1 write_data", bus.write_data, e[31:0]);
                    end
                end
            end
            if (bus.req0_valid && bus.req0_ready && bus.req0_reg != 5'd0)
                q0.push_back({bus.req0_reg, bus.req0_data});
            if (bus.req1_valid && bus.req1_ready && bus.req1_reg != 5'd0)
                q1.push_back({bus.req1_reg, bus.req1_data});
        end
    end

    initial begin
        logic expGid;
        logic expR0;
        logic expR1;
        int   expCnt;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_reg   = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_reg   = '0;
        bus.req1_data  = '0;

        //          v0    r0     d0             v1    r1     d1             rdy0  rdy1  rw    gid   cnt
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h1234,     1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
        vecs[7]  = '{1'b1, 5'd9,  32'hA5A50001, 1'b1, 5'd12, 32'h0000BEEF, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd20, 32'h20,       1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd20, 32'h20,       1'b1, 1'b1, 1'b1, 1'b0, 8'd1};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 8'd1};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 8'd1};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 8'd1};

        // Reset with a request offered on the reset edge; it must be dropped.
        @(posedge clk);
        #1;
        checkOutput("rst ready0", {31'd0, bus.req0_ready}, 32'd1);
        checkOutput("rst ready1", {31'd0, bus.req1_ready}, 32'd1);
        bus.req0_valid = 1'b1;
        bus.req0_reg   = 5'd5;
        bus.req0_data  = 32'h55;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        #1;
        checkOutput("rst reg_write", {31'd0, bus.reg_write}, 32'd0);
        checkOutput("rst write_reg", {27'd0, bus.write_reg}, 32'd0);
        checkOutput("rst write_data", bus.write_data, 32'd0);
        checkOutput("rst grant_id", {31'd0, bus.grant_id}, 32'd0);
        checkOutput("rst contend_cnt", {24'd0, bus.contend_cnt}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            checkOutput($sformatf("post-rst idle%0d reg_write", i), {31'd0, bus.reg_write}, 32'd0);
        end

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].v0, vecs[i].r0, vecs[i].d0, vecs[i].v1, vecs[i].r1, vecs[i].d1);
            checkOutput($sformatf("vec%0d ready0", i), {31'd0, bus.req0_ready}, {31'd0, vecs[i].eRdy0});
            checkOutput($sformatf("vec%0d ready1", i), {31'd0, bus.req1_ready}, {31'd0, vecs[i].eRdy1});
            checkOutput($sformatf("vec%0d reg_write", i), {31'd0, bus.reg_write}, {31'd0, vecs[i].eRw});
            checkOutput($sformatf("vec%0d grant_id", i), {31'd0, bus.grant_id}, {31'd0, vecs[i].eGid});
            checkOutput($sformatf("vec%0d contend_cnt", i), {24'd0, bus.contend_cnt}, {24'd0, vecs[i].eCnt});
        end

        // Continuous contention, long enough to saturate the counter.
        for (int k = 0; k < 305; k++) begin
            applyStimulus(1'b1, 5'd3, 32'h300 + k, 1'b1, 5'd7, 32'h700 + k);
            expCnt = (k < 1) ? 1 : ((k > 255) ? 255 : k);
            checkOutput($sformatf("cont%0d contend_cnt", k), {24'd0, bus.contend_cnt}, expCnt);
            if (k < 12) begin
`ifdef REG_WB_ARB_FIXED_PRIO_EN
                expGid = (k < 2) ? 1'b1 : 1'b0;
                expR0  = 1'b1;
                expR1  = (k == 0);
`else
                expGid = (k < 2) ? 1'b1 : k[0];
                expR0  = (k == 0) ? 1'b1 : k[0];
                expR1  = (k == 0) ? 1'b1 : ~k[0];
`endif
                checkOutput($sformatf("cont%0d reg_write", k), {31'd0, bus.reg_write}, (k >= 2) ? 32'd1 : 32'd0);
                checkOutput($sformatf("cont%0d grant_id", k), {31'd0, bus.grant_id}, {31'd0, expGid});
                checkOutput($sformatf("cont%0d ready0", k), {31'd0, bus.req0_ready}, {31'd0, expR0});
                checkOutput($sformatf("cont%0d ready1", k), {31'd0, bus.req1_ready}, {31'd0, expR1});
            end
        end

        // One-cycle reset with both buffers full and requests still offered.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        checkOutput("midrst reg_write", {31'd0, bus.reg_write}, 32'd0);
        checkOutput("midrst contend_cnt", {24'd0, bus.contend_cnt}, 32'd0);
        checkOutput("midrst ready0", {31'd0, bus.req0_ready}, 32'd1);
        checkOutput("midrst ready1", {31'd0, bus.req1_ready}, 32'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("midrst idle reg_write", {31'd0, bus.reg_write}, 32'd0);
        applyStimulus(1'b1, 5'd3, 32'hC0DE0003, 1'b1, 5'd7, 32'hC0DE0007);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("tie ready0", {31'd0, bus.req0_ready}, 32'd1);
        checkOutput("tie ready1", {31'd0, bus.req1_ready}, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("tie reg_write", {31'd0, bus.reg_write}, 32'd1);
        checkOutput("tie grant_id", {31'd0, bus.grant_id}, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("tie2 reg_write", {31'd0, bus.reg_write}, 32'd1);
        checkOutput("tie2 grant_id", {31'd0, bus.grant_id}, 32'd1);

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("drain q0 empty", q0.size(), 32'd0);
        checkOutput("drain q1 empty", q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
